// File: rtl/atsc_dc_blocker.sv
// atsc_dc_blocker: removes the DC residue left in the FPLL output by subtracting
// a 2^LOG2_LEN-sample moving average from the centre-delayed input sample.
// AXI-Stream in/out, one output per input, single registered output stage.
module atsc_dc_blocker #(
    parameter int LOG2_LEN = 4,
    parameter int DW       = 32
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic [DW-1:0] in_TDATA,
    input  logic          in_TVALID,
    output logic          in_TREADY,
    input  logic          in_TLAST,
    output logic [DW-1:0] out_TDATA,
    output logic          out_TVALID,
    input  logic          out_TREADY,
    output logic          out_TLAST
);

    localparam int N    = 1 << LOG2_LEN;
    localparam int HALF = N / 2;
    localparam int AW   = DW + LOG2_LEN;
    localparam int FW   = LOG2_LEN + 1;

    localparam logic [FW-1:0]       FILL_FULL = FW'(N);
    localparam logic [FW-1:0]       FILL_HALF = FW'(HALF);
    localparam logic [LOG2_LEN-1:0] HALF_OFF  = LOG2_LEN'(HALF);
    localparam logic [DW-1:0]       SAT_MAX   = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]       SAT_MIN   = {1'b1, {(DW-1){1'b0}}};

    // Reset synchroniser: assertion reaches the datapath immediately, release
    // is aligned to ap_clk so no flop sees a deasserting edge near the clock.
    logic rst_meta_q;
    logic rst_sync_n_q;

    // Two-stage async-assert / sync-deassert reset chain.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rst_meta_q   <= 1'b0;
            rst_sync_n_q <= 1'b0;
        end else begin
            // NOTE: clocked state always uses <= so every flop samples pre-edge values.
            rst_meta_q   <= 1'b1;
            rst_sync_n_q <= rst_meta_q;
        end
    end

    // Datapath state.
    logic [DW-1:0]        buf_mem [N];
    logic [LOG2_LEN-1:0]  wr_ptr_q, wr_ptr_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [FW-1:0]        fill_q, fill_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    // Combinational intermediates.
    logic                 accept;
    logic [DW-1:0]        old_s;
    logic [DW-1:0]        ctr_s;
    logic signed [AW-1:0] acc_sum;
    logic [DW-1:0]        avg_s;
    logic [DW:0]          diff_s;
    logic [DW-1:0]        y_sat;

    // The output register can take a new sample whenever it is empty or draining.
    assign in_TREADY  = !out_valid_q || out_TREADY;
    assign out_TDATA  = out_data_q;
    assign out_TVALID = out_valid_q;
    assign out_TLAST  = out_last_q;

    // Filter arithmetic and next-state selection for the accepted sample.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        wr_ptr_d    = wr_ptr_q;
        acc_d       = acc_q;
        fill_d      = fill_q;

        accept = in_TVALID && in_TREADY;

        // Oldest sample leaves the window only once the window is full;
        // the centre tap is valid once half the window has been written.
        old_s = (fill_q == FILL_FULL) ? buf_mem[wr_ptr_q] : '0;
        ctr_s = (fill_q >= FILL_HALF) ? buf_mem[wr_ptr_q - HALF_OFF] : '0;

        acc_sum = acc_q
                + {{LOG2_LEN{in_TDATA[DW-1]}}, in_TDATA}
                - {{LOG2_LEN{old_s[DW-1]}}, old_s};

        // Dropping the low LOG2_LEN bits of a signed value is the floor
        // (arithmetic) divide by N; the mean always fits in DW bits.
        avg_s = acc_sum[AW-1:LOG2_LEN];

        diff_s = {ctr_s[DW-1], ctr_s} - {avg_s[DW-1], avg_s};
        if (diff_s[DW] != diff_s[DW-1]) begin
            y_sat = diff_s[DW] ? SAT_MIN : SAT_MAX;
        end else begin
            y_sat = diff_s[DW-1:0];
        end

        if (accept) begin
            out_data_d  = y_sat;
            out_valid_d = 1'b1;
            out_last_d  = in_TLAST;
            acc_d       = acc_sum;
            wr_ptr_d    = wr_ptr_q + LOG2_LEN'(1);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end
        end else if (out_TREADY) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and output registers; history restarts on every reset.
    always_ff @(posedge ap_clk or negedge rst_sync_n_q) begin
        if (!rst_sync_n_q) begin
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Circular delay line written on every accepted sample.
    always_ff @(posedge ap_clk) begin
        // NOTE: the RAM has no reset; fill gates every read until a location is written.
        if (accept) begin
            buf_mem[wr_ptr_q] <= in_TDATA;
        end
    end

endmodule

// File: tb/tb_atsc_dc_blocker.sv
// tb_atsc_dc_blocker: directed bench for atsc_dc_blocker (N=16, DW=32).
module tb_atsc_dc_blocker;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [31:0] in_TDATA;
    logic        in_TVALID;
    logic        in_TREADY;
    logic        in_TLAST;
    logic [31:0] out_TDATA;
    logic        out_TVALID;
    logic        out_TREADY;
    logic        out_TLAST;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] stim     [0:127];
    logic [31:0] got_data [0:127];
    logic        got_last [0:127];
    int          n_got;

    atsc_dc_blocker #(.LOG2_LEN(4), .DW(32)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TREADY  (in_TREADY),
        .in_TLAST   (in_TLAST),
        .out_TDATA  (out_TDATA),
        .out_TVALID (out_TVALID),
        .out_TREADY (out_TREADY),
        .out_TLAST  (out_TLAST)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain window sum over the last 16 inputs of the current
    // stream, centre tap 8 samples back, zeros before the stream started.
    function automatic logic [31:0] model_y(input int k);
        longint sum;
        longint ctr;
        longint avg;
        longint d;
        sum = 0;
        for (int j = 0; j < 16; j++) begin
            if (k - j >= 0) sum += longint'($signed(stim[k-j]));
        end
        ctr = (k >= 8) ? longint'($signed(stim[k-8])) : 64'sd0;
        avg = sum >>> 4;
        d   = ctr - avg;
        if (d > 64'sd2147483647)       d = 64'sd2147483647;
        else if (d < -64'sd2147483648) d = -64'sd2147483648;
        return d[31:0];
    endfunction

    task automatic do_reset();
        in_TVALID  = 1'b0;
        in_TLAST   = 1'b0;
        out_TREADY = 1'b1;
        ap_rst_n   = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (4) @(negedge ap_clk);
    endtask

    // Push n samples from stim, collect n outputs; optional random backpressure
    // and TLAST every last_every samples. Checks hold-while-stalled on the way.
    task automatic run_stream(input int n, input bit rand_ready, input int last_every);
        int          sent;
        int          cyc;
        bit          stalled;
        logic [31:0] held;
        sent    = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        n_got   = 0;
        while (n_got < n && cyc < 2000) begin
            @(negedge ap_clk);
            out_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            in_TVALID  = (sent < n);
            in_TDATA   = (sent < n) ? stim[sent] : 32'd0;
            in_TLAST   = (last_every > 0) && (sent < n) && ((sent % last_every) == last_every - 1);
            #1;
            if (stalled) begin
                check("stall_valid", {31'd0, out_TVALID}, 32'd1);
                check("stall_hold", out_TDATA, held);
            end
            if (out_TVALID && out_TREADY) begin
                got_data[n_got] = out_TDATA;
                got_last[n_got] = out_TLAST;
                n_got++;
            end
            stalled = out_TVALID && !out_TREADY;
            held    = out_TDATA;
            if (in_TVALID && in_TREADY) sent++;
            cyc++;
        end
        check("stream_done", 32'(n_got), 32'(n));
        @(negedge ap_clk);
        in_TVALID  = 1'b0;
        in_TLAST   = 1'b0;
        out_TREADY = 1'b1;
        #1;
        check("no_extra", {31'd0, out_TVALID}, 32'd0);
    endtask

    task automatic check_model(input string scen, input int n);
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_y%0d", scen, k), got_data[k], model_y(k));
        end
    endtask

    initial begin
        ap_rst_n   = 1'b0;
        in_TDATA   = '0;
        in_TVALID  = 1'b0;
        in_TLAST   = 1'b0;
        out_TREADY = 1'b1;

        // Reset state.
        repeat (3) @(negedge ap_clk);
        #1;
        check("rst_valid", {31'd0, out_TVALID}, 32'd0);
        check("rst_data", out_TDATA, 32'd0);
        check("rst_last", {31'd0, out_TLAST}, 32'd0);
        check("rst_ready", {31'd0, in_TREADY}, 32'd1);
        do_reset();

        // 1: constant 1000, full throughput.
        for (int k = 0; k < 32; k++) stim[k] = 32'd1000;
        run_stream(32, 1'b0, 0);
        check("s1_y0", got_data[0], 32'hFFFF_FFC2);
        check("s1_y7", got_data[7], 32'hFFFF_FE0C);
        check("s1_y8", got_data[8], 32'd438);
        check("s1_y15", got_data[15], 32'd0);
        check("s1_y31", got_data[31], 32'd0);
        check_model("s1", 32);

        // 2: same stream with random downstream backpressure.
        do_reset();
        run_stream(32, 1'b1, 0);
        check("s2_y0", got_data[0], 32'hFFFF_FFC2);
        check("s2_y8", got_data[8], 32'd438);
        check_model("s2", 32);

        // 3: saturation on the positive rail.
        do_reset();
        for (int k = 0; k < 8; k++)  stim[k] = 32'h7FFF_FFFF;
        for (int k = 8; k < 16; k++) stim[k] = 32'h8000_0000;
        run_stream(16, 1'b0, 0);
        check("s3_y8", got_data[8], 32'h4800_0000);
        check("s3_y15", got_data[15], 32'h7FFF_FFFF);
        check_model("s3", 16);

        // 4: 5-sample packets, TLAST alignment under backpressure.
        do_reset();
        for (int k = 0; k < 20; k++) stim[k] = 32'(k * 37 - 300);
        run_stream(20, 1'b1, 5);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("s4_last%0d", k), {31'd0, got_last[k]}, {31'd0, (k % 5) == 4});
        end
        check_model("s4", 20);

        // 5: 100-sample ramp, exercises pointer wrap many times.
        do_reset();
        for (int k = 0; k < 100; k++) stim[k] = 32'(k);
        run_stream(100, 1'b0, 0);
        check("s5_y9", got_data[9], 32'hFFFF_FFFF);
        check("s5_y50", got_data[50], 32'd0);
        check("s5_y99", got_data[99], 32'd0);
        check_model("s5", 100);

        // 6: reset asserted between clock edges while an output is pending.
        do_reset();
        @(negedge ap_clk);
        in_TVALID  = 1'b1;
        in_TDATA   = 32'd1000;
        out_TREADY = 1'b0;
        @(negedge ap_clk);
        #1;
        check("s6_pre_valid", {31'd0, out_TVALID}, 32'd1);
        check("s6_pre_data", out_TDATA, 32'hFFFF_FFC2);
        #1;
        ap_rst_n = 1'b0;
        #1;
        check("s6_async_valid", {31'd0, out_TVALID}, 32'd0);
        check("s6_async_data", out_TDATA, 32'd0);
        in_TVALID  = 1'b0;
        out_TREADY = 1'b1;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (4) @(negedge ap_clk);
        for (int k = 0; k < 16; k++) stim[k] = 32'd1000;
        run_stream(16, 1'b0, 0);
        check("s6_y0", got_data[0], 32'hFFFF_FFC2);
        check("s6_y8", got_data[8], 32'd438);
        check("s6_y15", got_data[15], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
